// File: rtl/word_check_ctrl_pkg.sv
// Shared definitions for the typing-check controller: FSM encoding,
// scan-code constants and default timing parameters.
package word_check_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    WAIT_KEY,
    PENALTY,
    DONE
  } state_t;

  localparam logic [8:0] KEY_CODE_ENTER = 9'd90;
  localparam logic [8:0] WORD_END       = 9'd0;

  localparam int unsigned NUM_WORDS_DEF     = 16;
  localparam int unsigned PENALTY_CYC_DEF   = 50_000_000;
  localparam int unsigned TICKS_PER_SEC_DEF = 100_000_000;

endpackage

// File: rtl/word_check_ctrl_sec_ticker.sv
// One-second prescaler: counts enabled cycles and pulses tick on the last
// cycle of each second, wrapping back to zero.
module sec_ticker
  import word_check_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICKS_PER_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/word_check_ctrl.sv
// Typing-check session controller: fetches expected scan codes from a word
// ROM, compares key presses, counts words/errors and enforces a lockout.
module word_check_ctrl
  import word_check_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = NUM_WORDS_DEF,
  parameter int unsigned PENALTY_CYC   = PENALTY_CYC_DEF,
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  output logic [6:0] rom_addr,
  input  logic [8:0] rom_data,
  output logic       correct_n,
  output logic       done,
  output logic [4:0] word_cnt,
  output logic [7:0] err_cnt,
  output logic [7:0] elapsed_sec,
  output logic       busy
);

  localparam int unsigned PW = (PENALTY_CYC > 1) ? $clog2(PENALTY_CYC) : 1;

  state_t        state;
  logic [3:0]    word_idx;
  logic [2:0]    char_idx;
  logic [8:0]    exp_code;
  logic [PW-1:0] pen_cnt;
  logic          sess_start;
  logic          tick;
  logic          word_done;
  logic          last_word;

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign correct_n = (state != PENALTY);

  // In DONE an abort beats start; in IDLE abort has no effect.
  assign sess_start = start && ((state == IDLE) || ((state == DONE) && !abort));

  assign word_done = ((state == LOAD) && (rom_data == WORD_END)) ||
                     ((state == WAIT_KEY) && key_valid && (key_code == exp_code) &&
                      (char_idx == 3'd7));
  assign last_word = (word_idx == 4'(NUM_WORDS - 1));

  sec_ticker #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_ticker (
    .clk (clk),
    .rst (rst || sess_start),
    .en  (busy),
    .tick(tick)
  );

  // rom_addr is loaded on the edge entering ADDR so the synchronous ROM
  // presents its data during LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_idx    <= '0;
      char_idx    <= '0;
      word_cnt    <= '0;
      err_cnt     <= '0;
      elapsed_sec <= '0;
      exp_code    <= '0;
      rom_addr    <= '0;
      pen_cnt     <= '0;
    end else begin
      if (tick && (elapsed_sec != '1)) elapsed_sec <= elapsed_sec + 8'd1;

      if (abort && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state       <= ADDR;
              word_idx    <= '0;
              char_idx    <= '0;
              word_cnt    <= '0;
              err_cnt     <= '0;
              elapsed_sec <= '0;
              rom_addr    <= '0;
            end
          end
          ADDR: state <= LOAD;
          LOAD: begin
            exp_code <= rom_data;
            state    <= WAIT_KEY;
          end
          WAIT_KEY: begin
            if (key_valid) begin
              if (key_code != exp_code) begin
                if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
                pen_cnt <= '0;
                state   <= PENALTY;
              end else if (char_idx != 3'd7) begin
                char_idx <= char_idx + 3'd1;
                rom_addr <= {word_idx, char_idx + 3'd1};
                state    <= ADDR;
              end
            end
          end
          PENALTY: begin
            if (pen_cnt == PW'(PENALTY_CYC - 1)) state <= WAIT_KEY;
            else                                 pen_cnt <= pen_cnt + PW'(1);
          end
          default: state <= IDLE;
        endcase

        if (word_done) begin
          word_cnt <= word_cnt + 5'd1;
          word_idx <= word_idx + 4'd1;
          char_idx <= '0;
          if (last_word) begin
            state <= DONE;
          end else begin
            state    <= ADDR;
            rom_addr <= {word_idx + 4'd1, 3'd0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_word_check_ctrl.sv
// Self-checking bench for word_check_ctrl: directed scenarios plus randomized
// sessions checked against a word/error model.
module tb_word_check_ctrl;
  import word_check_ctrl_pkg::*;

  localparam int unsigned PEN = 10;

  logic       clk = 1'b0;
  logic       rst, start, abort, key_valid;
  logic [8:0] key_code;
  logic [6:0] rom_addr;
  logic [8:0] rom_data;
  logic       correct_n, done, busy;
  logic [4:0] word_cnt;
  logic [7:0] err_cnt, elapsed_sec;

  logic [8:0]  rom [128];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned low_cnt = 0;

  word_check_ctrl #(
    .NUM_WORDS    (1),
    .PENALTY_CYC  (PEN),
    .TICKS_PER_SEC(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .correct_n  (correct_n),
    .done       (done),
    .word_cnt   (word_cnt),
    .err_cnt    (err_cnt),
    .elapsed_sec(elapsed_sec),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) if (correct_n === 1'b0) low_cnt++;

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [8:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key_valid = 1'b1; key_code = 9'h1C;
    cyc(2);
    start = 1'b0; key_valid = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else passed++;
    total++; if (correct_n !== 1'b1) $display("FAIL rst_correct_n: got %0b want 1", correct_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
    total++; if (rom_addr !== 7'd0) $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); else passed++;
    total++; if (word_cnt !== 5'd0) $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); else passed++;
    total++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else passed++;
    total++; if (elapsed_sec !== 8'd0) $display("FAIL rst_elapsed: got %0d want 0", elapsed_sec); else passed++;
    rst = 1'b0;
    cyc(1);
    total++; if (busy !== 1'b0) $display("FAIL rst_idle_hold: busy got %0b want 0", busy); else passed++;
  endtask

  task automatic test_correct_word();
    int unsigned base;
    rom[0] = 9'h1C; rom[1] = 9'h32; rom[2] = WORD_END;
    base = low_cnt;
    pulse_start(); cyc(2);
    press(9'h1C); cyc(2);
    press(9'h32); cyc(3);
    total++; if (done !== 1'b1) $display("FAIL cw_done: got %0b want 1", done); else passed++;
    total++; if (word_cnt !== 5'd1) $display("FAIL cw_word_cnt: got %0d want 1", word_cnt); else passed++;
    total++; if (err_cnt !== 8'd0) $display("FAIL cw_err_cnt: got %0d want 0", err_cnt); else passed++;
    total++; if (low_cnt - base !== 0) $display("FAIL cw_no_penalty: low cycles %0d want 0", low_cnt - base); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL cw_busy: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_wrong_key();
    int unsigned base;
    pulse_start();
    total++; if (word_cnt !== 5'd0 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL wk_restart: word_cnt %0d done %0b busy %0b want 0 0 1", word_cnt, done, busy); else passed++;
    cyc(2);
    base = low_cnt;
    press(9'h1B);
    total++; if (correct_n !== 1'b0) $display("FAIL wk_penalty_entry: correct_n %0b want 0", correct_n); else passed++;
    total++; if (err_cnt !== 8'd1) $display("FAIL wk_err_cnt: got %0d want 1", err_cnt); else passed++;
    cyc(3);
    press(9'h1C);
    cyc(6);
    total++; if (low_cnt - base !== PEN) $display("FAIL wk_penalty_len: got %0d want %0d", low_cnt - base, PEN); else passed++;
    total++; if (correct_n !== 1'b1) $display("FAIL wk_penalty_exit: correct_n %0b want 1", correct_n); else passed++;
    total++; if (err_cnt !== 8'd1 || rom_addr !== 7'd0)
      $display("FAIL wk_key_ignored: err %0d rom_addr %0d want 1 0", err_cnt, rom_addr); else passed++;
    press(9'h1C);
    total++; if (rom_addr !== 7'd1) $display("FAIL wk_accept: rom_addr %0d want 1", rom_addr); else passed++;
    press(9'h55);
    cyc(1);
    total++; if (err_cnt !== 8'd1) $display("FAIL wk_drop_addr_load: err %0d want 1", err_cnt); else passed++;
    pulse_start();
    total++; if (rom_addr !== 7'd1 || busy !== 1'b1)
      $display("FAIL wk_start_busy: rom_addr %0d busy %0b want 1 1", rom_addr, busy); else passed++;
    press(9'h32); cyc(3);
    total++; if (done !== 1'b1 || word_cnt !== 5'd1 || err_cnt !== 8'd1)
      $display("FAIL wk_finish: done %0b words %0d err %0d want 1 1 1", done, word_cnt, err_cnt); else passed++;
  endtask

  task automatic test_eight_char();
    logic [8:0] codes [8];
    for (int i = 0; i < 8; i++) begin
      codes[i] = 9'($urandom_range(1, 511));
      rom[i]   = codes[i];
    end
    pulse_start(); cyc(2);
    for (int i = 0; i < 8; i++) begin
      press(codes[i]);
      if (i < 7) cyc(2);
    end
    total++; if (done !== 1'b1 || word_cnt !== 5'd1)
      $display("FAIL ec_complete: done %0b words %0d want 1 1", done, word_cnt); else passed++;
    total++; if (dut.word_idx !== 4'd1 || dut.char_idx !== 3'd0)
      $display("FAIL ec_indices: word_idx %0d char_idx %0d want 1 0", dut.word_idx, dut.char_idx); else passed++;
    total++; if (rom_addr !== 7'd7) $display("FAIL ec_rom_addr_hold: got %0d want 7", rom_addr); else passed++;
  endtask

  task automatic test_abort();
    logic [8:0] codes [8];
    for (int i = 0; i < 8; i++) begin
      codes[i] = 9'($urandom_range(1, 511));
      rom[i]   = codes[i];
    end
    pulse_start(); cyc(2);
    for (int i = 0; i < 7; i++) begin
      press(codes[i]); cyc(2);
    end
    abort = 1'b1; key_valid = 1'b1; key_code = codes[7];
    @(negedge clk);
    abort = 1'b0; key_valid = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL ab_idle: busy %0b done %0b want 0 0", busy, done); else passed++;
    total++; if (word_cnt !== 5'd0) $display("FAIL ab_word_cnt: got %0d want 0", word_cnt); else passed++;
    total++; if (rom_addr !== 7'd7) $display("FAIL ab_rom_addr_hold: got %0d want 7", rom_addr); else passed++;
    cyc(2);
    total++; if (busy !== 1'b0) $display("FAIL ab_stays_idle: busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_saturation();
    int unsigned exp_sec;
    rom[0] = 9'h1C; rom[1] = WORD_END;
    pulse_start();
    cyc(40);
    exp_sec = (40 / 4 > 255) ? 255 : 40 / 4;
    total++; if (elapsed_sec !== 8'(exp_sec)) $display("FAIL sat_elapsed_40: got %0d want %0d", elapsed_sec, exp_sec); else passed++;
    cyc(1100);
    exp_sec = (1140 / 4 > 255) ? 255 : 1140 / 4;
    total++; if (elapsed_sec !== 8'(exp_sec)) $display("FAIL sat_elapsed: got %0d want %0d", elapsed_sec, exp_sec); else passed++;
    for (int i = 0; i < 300; i++) begin
      press(9'h1B); cyc(PEN);
    end
    total++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt: got %0d want 255", err_cnt); else passed++;
    total++; if (busy !== 1'b1 || correct_n !== 1'b1)
      $display("FAIL sat_waiting: busy %0b correct_n %0b want 1 1", busy, correct_n); else passed++;
    abort = 1'b1; cyc(1); abort = 1'b0;
    total++; if (busy !== 1'b0 || err_cnt !== 8'd255 || elapsed_sec !== 8'd255)
      $display("FAIL sat_abort_hold: busy %0b err %0d sec %0d want 0 255 255", busy, err_cnt, elapsed_sec); else passed++;
  endtask

  task automatic test_random_sessions();
    logic [8:0]  word [$];
    logic [8:0]  k;
    int unsigned len, pos, errs, dead, base, steps;
    for (int s = 0; s < 6; s++) begin
      word.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) begin
        if (i < int'(len)) begin
          word.push_back(9'($urandom_range(1, 511)));
          rom[i] = word[i];
        end else begin
          rom[i] = WORD_END;
        end
      end
      pulse_start(); cyc(2);
      base = low_cnt; pos = 0; errs = 0; steps = 0;
      while (pos < len) begin
        steps++;
        if (steps > 30 || $urandom_range(1) == 1) begin
          press(word[pos]);
          pos++;
          dead = (pos < len) ? 2 : 0;
        end else begin
          do k = 9'($urandom_range(1, 511)); while (k == word[pos]);
          press(k);
          errs++;
          dead = PEN;
        end
        for (int d = 0; d < int'(dead); d++) begin
          if ($urandom_range(2) == 0) press(($urandom_range(1) == 1) ? KEY_CODE_ENTER : 9'($urandom));
          else cyc(1);
        end
      end
      cyc(3);
      total++; if (done !== 1'b1 || word_cnt !== 5'd1)
        $display("FAIL rnd_complete[%0d]: done %0b words %0d want 1 1", s, done, word_cnt); else passed++;
      total++; if (err_cnt !== 8'((errs > 255) ? 255 : errs))
        $display("FAIL rnd_err_cnt[%0d]: got %0d want %0d", s, err_cnt, errs); else passed++;
      total++; if (low_cnt - base !== PEN * errs)
        $display("FAIL rnd_penalty_cycles[%0d]: got %0d want %0d", s, low_cnt - base, PEN * errs); else passed++;
    end
  endtask

  task automatic test_rst_penalty();
    rom[0] = 9'h1C; rom[1] = 9'h32; rom[2] = WORD_END;
    pulse_start(); cyc(2);
    press(9'h1C); cyc(2);
    press(9'h77);
    cyc(3);
    rst = 1'b1; key_valid = 1'b1; key_code = 9'h32; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; start = 1'b0; abort = 1'b0;
    total++; if (correct_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rp_flags: correct_n %0b busy %0b done %0b want 1 0 0", correct_n, busy, done); else passed++;
    total++; if (rom_addr !== 7'd0 || word_cnt !== 5'd0 || err_cnt !== 8'd0 || elapsed_sec !== 8'd0)
      $display("FAIL rp_counters: addr %0d words %0d err %0d sec %0d want 0 0 0 0",
               rom_addr, word_cnt, err_cnt, elapsed_sec); else passed++;
    pulse_start();
    total++; if (rom_addr !== 7'd0 || busy !== 1'b1)
      $display("FAIL rp_restart: rom_addr %0d busy %0b want 0 1", rom_addr, busy); else passed++;
    cyc(2);
    press(9'h1C);
    total++; if (rom_addr !== 7'd1 || err_cnt !== 8'd0)
      $display("FAIL rp_first_key: rom_addr %0d err %0d want 1 0", rom_addr, err_cnt); else passed++;
    cyc(4);
    total++; if (elapsed_sec !== 8'd1) $display("FAIL rp_prescaler: sec %0d want 1", elapsed_sec); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; key_valid = 1'b0; key_code = '0;
    @(negedge clk);
    test_reset();
    test_correct_word();
    test_wrong_key();
    test_eight_char();
    test_abort();
    test_saturation();
    test_random_sessions();
    test_rst_penalty();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
